// File: rtl/ms_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : ms_ff_bank
// Purpose  : Bank of WIDTH master-slave flip-flops sharing one runtime-
//            selectable function (JK / SR / D / T). The master evaluates the
//            next state, and the slave presents it one edge later. Per-bit
//            SR-illegal flags and slave-change pulses are also reported.
// Revision : 1.0 - initial release
// ============================================================================
module ms_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] mq,
  output logic [WIDTH-1:0] sr_err,
  output logic [WIDTH-1:0] changed
);

  localparam logic [1:0] c_MODE_JK = 2'b00;
  localparam logic [1:0] c_MODE_SR = 2'b01;
  localparam logic [1:0] c_MODE_D  = 2'b10;
  localparam logic [1:0] c_MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_sr_err;
  logic [WIDTH-1:0] r_changed;
  logic [WIDTH-1:0] w_next;

  // Next master value for one bit. {jb,kb} is ordered with J/S as the MSB.
  // SR 11 holds the bit; the illegal condition is flagged separately.
  function automatic logic f_next_bit(input logic [1:0] md, input logic m,
                                      input logic jb, input logic kb);
    logic r;
    r = m;
    case (md)
      c_MODE_JK: begin
        case ({jb, kb})
          2'b00:   r = m;
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = ~m;
        endcase
      end
      c_MODE_SR: begin
        case ({jb, kb})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = m;
        endcase
      end
      c_MODE_D: r = jb;
      c_MODE_T: r = m ^ jb;
      default:  r = m;
    endcase
    return r;
  endfunction

  // Each bit is evaluated independently against its own master state.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_next[i] = f_next_bit(mode, r_mq[i], j[i], k[i]);
    end
  endgenerate

  // Master/slave pipeline plus per-bit status flags. The slave copies the
  // master on every non-reset edge so a disabled bank still drains its last
  // master value into q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mq      <= RESET_VAL;
      r_q       <= RESET_VAL;
      r_sr_err  <= '0;
      r_changed <= '0;
    end else begin
      if (en) begin
        r_mq <= w_next;
      end
      r_q       <= r_mq;
      r_sr_err  <= (en && (mode == c_MODE_SR)) ? (j & k) : '0;
      r_changed <= r_mq ^ r_q;
    end
  end

  assign q       = r_q;
  assign q_bar   = ~r_q;
  assign mq      = r_mq;
  assign sr_err  = r_sr_err;
  assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_ms_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_ff_bank
// Purpose  : Directed scoreboard bench for ms_ff_bank (WIDTH=4,
//            RESET_VAL=4'b1010). Each vector carries hand-computed state
//            expected after its edge; a monitor compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_ff_bank;

  localparam int         c_W   = 4;
  localparam logic [3:0] c_RST = 4'b1010;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [c_W-1:0]   j;
  logic [c_W-1:0]   k;
  logic [c_W-1:0]   q;
  logic [c_W-1:0]   q_bar;
  logic [c_W-1:0]   mq;
  logic [c_W-1:0]   sr_err;
  logic [c_W-1:0]   changed;

  typedef struct {
    string      name;
    logic [3:0] mq;
    logic [3:0] q;
    logic [3:0] sr;
    logic [3:0] ch;
  } exp_t;

  exp_t r_sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  ms_ff_bank #(
    .WIDTH     (c_W),
    .RESET_VAL (c_RST)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .q       (q),
    .q_bar   (q_bar),
    .mq      (mq),
    .sr_err  (sr_err),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector on the falling edge and queue the state expected
  // just after the following rising edge.
  task automatic vec(input string nm, input logic rn, input logic e,
                     input logic [1:0] md, input logic [3:0] jj,
                     input logic [3:0] kk, input logic [3:0] emq,
                     input logic [3:0] eq, input logic [3:0] esr,
                     input logic [3:0] ech);
    exp_t x;
    @(negedge clk);
    rst_n = rn;
    en    = e;
    mode  = md;
    j     = jj;
    k     = kk;
    x.name = nm;
    x.mq   = emq;
    x.q    = eq;
    x.sr   = esr;
    x.ch   = ech;
    r_sb.push_back(x);
  endtask

  // Monitor: one DUT observation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (r_sb.size() > 0) begin
        x = r_sb.pop_front();
        n_vec++;
        if (mq !== x.mq) begin
          n_fail++;
          $display("FAIL %s mq: got %b want %b", x.name, mq, x.mq);
        end
        if (q !== x.q) begin
          n_fail++;
          $display("FAIL %s q: got %b want %b", x.name, q, x.q);
        end
        if (q_bar !== ~x.q) begin
          n_fail++;
          $display("FAIL %s q_bar: got %b want %b", x.name, q_bar, ~x.q);
        end
        if (sr_err !== x.sr) begin
          n_fail++;
          $display("FAIL %s sr_err: got %b want %b", x.name, sr_err, x.sr);
        end
        if (changed !== x.ch) begin
          n_fail++;
          $display("FAIL %s changed: got %b want %b", x.name, changed, x.ch);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    j     = '0;
    k     = '0;
    //   name        rst en mode   j        k        mq       q        sr       ch
    vec("reset0",    0, 0, 2'b00, 4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    vec("reset1",    0, 1, 2'b01, 4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    vec("d_clr0",    1, 1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
    vec("d_clr1",    1, 1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010);
    vec("jk_sweep",  1, 1, 2'b00, 4'b1100, 4'b1010, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    vec("jk_hold0",  1, 1, 2'b00, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b1100);
    vec("jk_hold1",  1, 1, 2'b00, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    vec("d_0011",    1, 1, 2'b10, 4'b0011, 4'b0000, 4'b0011, 4'b1100, 4'b0000, 4'b0000);
    vec("sr_illeg",  1, 1, 2'b01, 4'b0101, 4'b0110, 4'b0001, 4'b0011, 4'b0100, 4'b1111);
    vec("sr_hold",   1, 1, 2'b01, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010);
    vec("sr_en0",    1, 0, 2'b01, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    vec("d_0000",    1, 1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    vec("t_tog0",    1, 1, 2'b11, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    vec("t_tog1",    1, 1, 2'b11, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    vec("t_tog2",    1, 1, 2'b11, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    vec("t_en0a",    1, 0, 2'b11, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    vec("t_en0b",    1, 0, 2'b11, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    vec("t_en0c",    1, 0, 2'b11, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    vec("d_0110",    1, 1, 2'b10, 4'b0110, 4'b0000, 4'b0110, 4'b1111, 4'b0000, 4'b0000);
    vec("mid_rst",   0, 1, 2'b10, 4'b0110, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    vec("post_rst",  1, 1, 2'b11, 4'b0001, 4'b0000, 4'b1011, 4'b1010, 4'b0000, 4'b0000);
    vec("jk_0101",   1, 1, 2'b00, 4'b0101, 4'b1010, 4'b0101, 4'b1011, 4'b0000, 4'b0001);
    vec("jk_keep0",  1, 1, 2'b00, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b1110);
    vec("jk_keep1",  1, 1, 2'b00, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
    vec("sw_to_d",   1, 1, 2'b10, 4'b1001, 4'b1111, 4'b1001, 4'b0101, 4'b0000, 4'b0000);
    vec("d_settle",  1, 1, 2'b10, 4'b1001, 4'b1111, 4'b1001, 4'b1001, 4'b0000, 4'b1100);

    // Let the monitor drain the scoreboard, bounded by a cycle budget.
    for (int c = 0; c < 20 && r_sb.size() > 0; c++) begin
      @(posedge clk);
      #2;
    end
    if (r_sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", r_sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
